// File: rtl/pipe_reg_chain.sv
// Chain of pipeline registers with per-slot stall, flush and valid tracking.
// Slot 0 takes the incoming payload. Each later slot takes the contents of the
// slot in front of it. A stall freezes its own slot and every slot upstream of it.
// A bubble is inserted directly behind the frozen group.
// A retire counter, saturating at all-ones, counts valid payloads leaving the last slot.
module pipe_reg_chain #(
    parameter int          WIDTH    = 32,
    parameter int          NUM_REGS = 4,
    parameter logic [31:0] BUBBLE   = 32'h00000013,
    parameter int          CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_REGS-1:0]       stall,
    input  logic [NUM_REGS-1:0]       flush,
    output logic [NUM_REGS*WIDTH-1:0] slot_data,
    output logic [NUM_REGS-1:0]       slot_valid,
    output logic [CNT_W-1:0]          retire_cnt
);

    localparam int                LAST     = NUM_REGS - 1;
    localparam logic [WIDTH-1:0]  BUBBLE_W = WIDTH'(BUBBLE);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [NUM_REGS-1:0][WIDTH-1:0] data_q;
    logic [NUM_REGS-1:0][WIDTH-1:0] data_d;
    logic [NUM_REGS-1:0]            valid_q;
    logic [NUM_REGS-1:0]            valid_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W-1:0]               cnt_d;
    logic [NUM_REGS-1:0]            hold;
    logic                           retire_fire;

    // Hold ripples from the tail toward slot 0: any stalled slot freezes everything upstream.
    always_comb begin
        hold       = '0;
        hold[LAST] = stall[LAST];
        for (int k = NUM_REGS - 2; k >= 0; k--) begin
            hold[k] = stall[k] | hold[k + 1];
        end
    end

    // Next slot contents, checked in priority order: flush, then hold, then load or bubble.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;

        // Slot 0 is fed from the upstream input.
        if (flush[0]) begin
            data_d[0]  = BUBBLE_W;
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            data_d[0]  = in_data;
            valid_d[0] = in_valid;
        end

        // Later slots take from the slot in front, or a bubble if that slot is frozen.
        for (int k = 1; k < NUM_REGS; k++) begin
            if (flush[k]) begin
                data_d[k]  = BUBBLE_W;
                valid_d[k] = 1'b0;
            end else if (hold[k]) begin
                data_d[k]  = data_q[k];
                valid_d[k] = valid_q[k];
            end else if (hold[k - 1]) begin
                data_d[k]  = BUBBLE_W;
                valid_d[k] = 1'b0;
            end else begin
                data_d[k]  = data_q[k - 1];
                valid_d[k] = valid_q[k - 1];
            end
        end
    end

    // Count real payloads that leave the tail this cycle; stop at all-ones rather than wrap.
    always_comb begin
        retire_fire = valid_q[LAST] & ~hold[LAST] & ~flush[LAST];
        cnt_d       = cnt_q;
        if (retire_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers. Reset discards every slot without counting a retirement.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= {NUM_REGS{BUBBLE_W}};
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready   = ~hold[0];
    assign slot_data  = data_q;
    assign slot_valid = valid_q;
    assign retire_cnt = cnt_q;

endmodule
